// File: rtl/pipeline_ctrl_gen.sv
// Pipeline stall/flush controller: priority stall resolution, held flush with exception redirect PC.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl_gen #(
  parameter int unsigned               STAGES        = 8,
  parameter int unsigned               FLUSH_CYCLES  = 1,
  parameter int unsigned               EXC_TYPE_W    = 32,
  parameter logic [EXC_TYPE_W-1:0]     EXC_TYPE_NULL = '0,
  parameter logic [EXC_TYPE_W-1:0]     EXC_TYPE_ERET = EXC_TYPE_W'(32'h0000_000e),
  parameter logic [31:0]               EXC_VECTOR    = 32'hbfc0_0380,
  parameter logic [31:0]               INIT_PC       = 32'hbfc0_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [STAGES-1:0]     stall_req_i,
  input  logic                  stall_all_i,
  input  logic [EXC_TYPE_W-1:0] exception_type_i,
  input  logic [31:0]           cp0_epc_i,
  output logic [STAGES-1:0]     stall_o,
  output logic [STAGES-1:0]     bubble_o,
  output logic                  flush_o,
  output logic [31:0]           exc_pc_o,
  output logic                  flush_busy_o,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           flush_count_o
);

  // state    | meaning
  // ST_RUN   | normal flow; flush follows exception_type combinationally
  // ST_FLUSH | holding flush for the remaining cycles; new exceptions dropped
  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  localparam int unsigned CNT_W = 4;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        exc_pc_q, exc_pc_d;

  logic               exc;
  logic [31:0]        target_pc;
  logic [STAGES-1:0]  req_mask;
  logic [STAGES-1:0]  stall_w;

  assign exc       = (exception_type_i != EXC_TYPE_NULL);
  assign target_pc = (exception_type_i == EXC_TYPE_ERET) ? cp0_epc_i : EXC_VECTOR;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      exc_pc_q <= INIT_PC;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exc_pc_q <= exc_pc_d;
    end
  end

  // A freeze in the entry cycle costs one extra hold cycle, hence the larger load.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exc_pc_d = exc_pc_q;
    case (state_q)
      ST_RUN: begin
        if (exc) begin
          exc_pc_d = target_pc;
          if ((FLUSH_CYCLES > 1) || stall_all_i) begin
            state_d = ST_FLUSH;
            cnt_d   = stall_all_i ? CNT_W'(FLUSH_CYCLES) : CNT_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      ST_FLUSH: begin
        if (!stall_all_i) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    flush_o      = 1'b0;
    exc_pc_o     = INIT_PC;
    flush_busy_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ST_RUN: begin
          flush_o  = exc;
          exc_pc_o = exc ? target_pc : INIT_PC;
        end
        ST_FLUSH: begin
          flush_o      = 1'b1;
          exc_pc_o     = exc_pc_q;
          flush_busy_o = 1'b1;
        end
        default: begin
          flush_o = 1'b0;
        end
      endcase
    end
  end

  // Stage j stalls when any stage at or above j requests a stall.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    req_mask = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc         = acc | stall_req_i[i];
      req_mask[i] = acc;
    end
  end

  always_comb begin
    if (rst_i)            stall_w = '0;
    else if (stall_all_i) stall_w = '1;
    else if (flush_o)     stall_w = '0;
    else                  stall_w = req_mask;
  end

  assign stall_o = stall_w;

  always_comb begin
    bubble_o = '0;
    for (int i = 0; i < STAGES - 1; i++) begin
      bubble_o[i] = stall_w[i] & ~stall_w[i+1];
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if ((stall_w[0] || stall_all_i) && (stall_cycles_q != 32'hffff_ffff)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if ((state_q == ST_RUN) && exc && (flush_count_q != 32'hffff_ffff)) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = 32'h0;
  assign flush_count_o  = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_gen.sv
// Bench for pipeline_ctrl_gen: two instances (3-cycle and 1-cycle flush) against a flush-debt model.
module tb_pipeline_ctrl_gen;
  localparam logic [31:0] VEC  = 32'hbfc0_0380;
  localparam logic [31:0] INIT = 32'hbfc0_0000;
  localparam logic [31:0] ERET = 32'h0000_000e;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  stall_req;
  logic        stall_all;
  logic [31:0] exc_type;
  logic [31:0] epc;

  logic [7:0]  d_stall  [2];
  logic [7:0]  d_bubble [2];
  logic        d_flush  [2];
  logic [31:0] d_pc     [2];
  logic        d_busy   [2];
  logic [31:0] d_sc     [2];
  logic [31:0] d_fc     [2];

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  // owed = flush cycles still due after the current one; freeze cycles do not pay it down
  int          owed  [2] = '{0, 0};
  logic [31:0] saved [2] = '{INIT, INIT};
  logic [31:0] m_sc  [2] = '{32'h0, 32'h0};
  logic [31:0] m_fc  [2] = '{32'h0, 32'h0};
  int          fcs   [2] = '{3, 1};

  always #5 clk = ~clk;

  pipeline_ctrl_gen #(.STAGES(8), .FLUSH_CYCLES(3)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .stall_req_i(stall_req), .stall_all_i(stall_all),
    .exception_type_i(exc_type), .cp0_epc_i(epc),
    .stall_o(d_stall[0]), .bubble_o(d_bubble[0]), .flush_o(d_flush[0]), .exc_pc_o(d_pc[0]),
    .flush_busy_o(d_busy[0]), .stall_cycles_o(d_sc[0]), .flush_count_o(d_fc[0])
  );

  pipeline_ctrl_gen #(.STAGES(8), .FLUSH_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .stall_req_i(stall_req), .stall_all_i(stall_all),
    .exception_type_i(exc_type), .cp0_epc_i(epc),
    .stall_o(d_stall[1]), .bubble_o(d_bubble[1]), .flush_o(d_flush[1]), .exc_pc_o(d_pc[1]),
    .flush_busy_o(d_busy[1]), .stall_cycles_o(d_sc[1]), .flush_count_o(d_fc[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] resolve(input logic [7:0] req);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) if (req[i]) m = 8'((1 << (i + 1)) - 1);
    return m;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        logic        busy, exc, e_flush, e_busy;
        logic [31:0] tgt, e_pc, e_sc, e_fc;
        logic [7:0]  e_stall, e_bub;
        busy = (owed[d] > 0);
        exc  = (exc_type != 32'h0);
        tgt  = (exc_type == ERET) ? epc : VEC;
        if (rst) begin
          e_flush = 1'b0; e_pc = INIT; e_busy = 1'b0; e_stall = 8'h00;
        end else begin
          e_flush = busy | exc;
          e_pc    = busy ? saved[d] : (exc ? tgt : INIT);
          e_busy  = busy;
          e_stall = stall_all ? 8'hff : (e_flush ? 8'h00 : resolve(stall_req));
        end
        e_bub = e_stall & ~(e_stall >> 1) & 8'h7f;
`ifdef PIPE_PERF_CNT_EN
        e_sc = m_sc[d];
        e_fc = m_fc[d];
`else
        e_sc = 32'h0;
        e_fc = 32'h0;
`endif
        chk($sformatf("d%0d.stall", d),        {24'h0, d_stall[d]},  {24'h0, e_stall});
        chk($sformatf("d%0d.bubble", d),       {24'h0, d_bubble[d]}, {24'h0, e_bub});
        chk($sformatf("d%0d.flush", d),        {31'h0, d_flush[d]},  {31'h0, e_flush});
        chk($sformatf("d%0d.exc_pc", d),       d_pc[d],              e_pc);
        chk($sformatf("d%0d.flush_busy", d),   {31'h0, d_busy[d]},   {31'h0, e_busy});
        chk($sformatf("d%0d.stall_cycles", d), d_sc[d],              e_sc);
        chk($sformatf("d%0d.flush_count", d),  d_fc[d],              e_fc);
        if (rst) begin
          owed[d] = 0; saved[d] = INIT; m_sc[d] = 32'h0; m_fc[d] = 32'h0;
        end else begin
          if ((e_stall[0] || stall_all) && m_sc[d] != 32'hffff_ffff) m_sc[d] = m_sc[d] + 1;
          if (busy) begin
            if (!stall_all) owed[d] = owed[d] - 1;
          end else if (exc) begin
            saved[d] = tgt;
            owed[d]  = fcs[d] - (stall_all ? 0 : 1);
            if (m_fc[d] != 32'hffff_ffff) m_fc[d] = m_fc[d] + 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; stall_req = 8'h00; stall_all = 1'b0; exc_type = 32'h0; epc = 32'h0;
  endtask

  initial begin
    rst = 1'b1; stall_req = 8'h00; stall_all = 1'b0; exc_type = 32'h0; epc = 32'h0;
    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1 idle();

    // priority resolution
    stall_req = 8'b0001_1000; #1;
    chk("lit.stall_req18", {24'h0, d_stall[0]}, 32'h1f);
    chk("lit.bubble_req18", {24'h0, d_bubble[0]}, 32'h10);
    step(); stall_req = 8'h00; #1;
    chk("lit.stall_none", {24'h0, d_stall[1]}, 32'h00);
    step(); stall_all = 1'b1; stall_req = 8'b0000_0100; #1;
    chk("lit.freeze_stall", {24'h0, d_stall[0]}, 32'hff);
    chk("lit.freeze_bubble", {24'h0, d_bubble[0]}, 32'h00);

    // 3-cycle flush; repeat exception in cycle 2 is dropped
    step(); idle(); exc_type = 32'h1; #1;
    chk("lit.exc_c1_flush", {31'h0, d_flush[0]}, 32'h1);
    chk("lit.exc_c1_pc", d_pc[0], VEC);
    chk("lit.exc_c1_busy", {31'h0, d_busy[0]}, 32'h0);
    step(); #1;
    chk("lit.exc_c2_busy", {31'h0, d_busy[0]}, 32'h1);
    chk("lit.exc_c2_pc", d_pc[0], VEC);
    step(); exc_type = 32'h0; #1;
    chk("lit.exc_c3_flush", {31'h0, d_flush[0]}, 32'h1);
    step(); #1;
    chk("lit.exc_c4_flush", {31'h0, d_flush[0]}, 32'h0);

    // ERET on the single-cycle instance
    step(); exc_type = ERET; epc = 32'h8000_1234; #1;
    chk("lit.eret_flush", {31'h0, d_flush[1]}, 32'h1);
    chk("lit.eret_pc", d_pc[1], 32'h8000_1234);
    step(); exc_type = 32'h0; #1;
    chk("lit.eret_next_flush", {31'h0, d_flush[1]}, 32'h0);
    chk("lit.eret_next_pc", d_pc[1], INIT);
    repeat (3) step();

    // freeze over a 3-cycle flush stretches it to 5
    exc_type = 32'h1;
    step(); exc_type = 32'h0; stall_all = 1'b1; #1;
    chk("lit.frz_c2_flush", {31'h0, d_flush[0]}, 32'h1);
    chk("lit.frz_c2_stall", {24'h0, d_stall[0]}, 32'hff);
    step(); #1;
    chk("lit.frz_c3_pc", d_pc[0], VEC);
    step(); stall_all = 1'b0; #1;
    chk("lit.frz_c4_flush", {31'h0, d_flush[0]}, 32'h1);
    step(); #1;
    chk("lit.frz_c5_flush", {31'h0, d_flush[0]}, 32'h1);
    step(); #1;
    chk("lit.frz_c6_flush", {31'h0, d_flush[0]}, 32'h0);

    // reset in the middle of a hold
    exc_type = 32'h1;
    step(); exc_type = 32'h0; rst = 1'b1; #1;
    chk("lit.rst_flush", {31'h0, d_flush[0]}, 32'h0);
    chk("lit.rst_pc", d_pc[0], INIT);
    step(); rst = 1'b0; #1;
    chk("lit.rst_after_busy", {31'h0, d_busy[0]}, 32'h0);
    chk("lit.rst_after_flush", {31'h0, d_flush[0]}, 32'h0);

    // counters: 5 stall cycles then 2 exceptions
    step(); stall_req = 8'h01;
    repeat (5) step();
    stall_req = 8'h00; exc_type = 32'h1;
    step(); exc_type = 32'h0;
    step(); exc_type = 32'h1;
    step(); exc_type = 32'h0;
    step();
`ifdef PIPE_PERF_CNT_EN
    chk("lit.stall_cycles", d_sc[1], 32'd5);
    chk("lit.flush_count", d_fc[1], 32'd2);
`else
    chk("lit.stall_cycles_off", d_sc[1], 32'd0);
    chk("lit.flush_count_off", d_fc[1], 32'd0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      step();
      rst       = ($urandom_range(0, 59) == 0);
      stall_all = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 3);
      if (r == 0)      stall_req = 8'h00;
      else if (r == 1) stall_req = 8'(1 << $urandom_range(0, 7));
      else             stall_req = 8'($urandom);
      if ($urandom_range(0, 5) == 0)
        exc_type = ($urandom_range(0, 2) == 0) ? ERET : $urandom;
      else
        exc_type = 32'h0;
      epc = $urandom;
    end
    step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
